fifo_serializer: RTL and testbench



---
 rtl/fifo_serializer_pkg.sv | 17 +
 rtl/fifo_serializer_bit_timer.sv | 36 +++
 rtl/fifo_serializer.sv | 102 ++++++++++
 tb/tb_fifo_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_serializer_pkg.sv
// Shared types and sizing helpers for the FIFO-to-serial-line frame generator.
package fifo_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Counter width that stays legal (>= 1 bit) for a modulus of 1.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// Per-bit down-counter: flags the final clock cycle of each serial bit period.
module fifo_serializer_bit_timer
  import fifo_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic last_cycle_o
);

  localparam int unsigned CW = ctr_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reaching zero reloads, so consecutive bit periods follow with no gap.
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_cycle_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a synchronous FIFO and sends each as start/LSB-first data/stop.
module fifo_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_read_en_o,
  output logic             serial_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int unsigned IW = ctr_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             restart;
  logic             last_cycle;
  logic             pop;

  fifo_serializer_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .restart_i   (restart),
    .last_cycle_o(last_cycle)
  );

  assign pop = ~reset_i & enable_i & ~fifo_empty_i &
               ((state_q == ST_IDLE) | ((state_q == ST_STOP) & last_cycle));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        shift_d = fifo_data_i;
        idx_d   = '0;
        restart = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        if (last_cycle) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_cycle) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (last_cycle) state_d = pop ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    serial_o = 1'b1;
    case (state_q)
      ST_START: serial_o = 1'b0;
      ST_DATA:  serial_o = shift_q[0];
      default:  serial_o = 1'b1;
    endcase
  end

  assign fifo_read_en_o = pop;
  assign busy_o         = (state_q != ST_IDLE);
  assign frame_done_o   = (state_q == ST_STOP) & last_cycle;

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench: two serializer configurations, each fed by a small FIFO model.
module tb_fifo_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: WIDTH=8, CLKS_PER_BIT=4
  logic       reset_a = 1'b1, enable_a = 1'b1;
  logic       empty_a, rd_a_o, ser_a, busy_a, fd_a;
  logic [7:0] data_a = '0;
  logic [7:0] mem_a [0:15];
  int         wr_a = 0, rp_a = 0, pops_a = 0;

  // DUT B: WIDTH=16, CLKS_PER_BIT=1
  logic        reset_b = 1'b1, enable_b = 1'b0;
  logic        empty_b, rd_b_o, ser_b, busy_b, fd_b;
  logic [15:0] data_b = '0;
  logic [15:0] mem_b [0:15];
  int          wr_b = 0, rp_b = 0, pops_b = 0;

  assign empty_a = (wr_a == rp_a);
  assign empty_b = (wr_b == rp_b);

  always @(posedge clk) begin
    if (rd_a_o) begin
      data_a <= mem_a[rp_a[3:0]];
      rp_a   <= rp_a + 1;
      pops_a <= pops_a + 1;
    end
    if (rd_b_o) begin
      data_b <= mem_b[rp_b[3:0]];
      rp_b   <= rp_b + 1;
      pops_b <= pops_b + 1;
    end
  end

  fifo_serializer #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk_i(clk), .reset_i(reset_a), .enable_i(enable_a), .fifo_empty_i(empty_a),
    .fifo_data_i(data_a), .fifo_read_en_o(rd_a_o), .serial_o(ser_a),
    .busy_o(busy_a), .frame_done_o(fd_a));

  fifo_serializer #(.WIDTH(16), .CLKS_PER_BIT(1)) dut_b (
    .clk_i(clk), .reset_i(reset_b), .enable_i(enable_b), .fifo_empty_i(empty_b),
    .fifo_data_i(data_b), .fifo_read_en_o(rd_b_o), .serial_o(ser_b),
    .busy_o(busy_b), .frame_done_o(fd_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] x);
    mem_a[wr_a[3:0]] = x;
    wr_a++;
  endtask

  // Returns with the pop visible in the current cycle; timeout counts as a failure.
  task automatic wait_pop(input bit sel);
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((sel ? rd_b_o : rd_a_o) === 1'b1) return;
      @(negedge clk);
    end
    chk("pop_timeout", 32'd0, 32'd1);
  endtask

  // Called in the pop cycle; walks FETCH plus the whole frame.
  task automatic frame(input bit sel, input logic [15:0] word, input int w, input int c,
                       input bit pop_end, input int drop_en_at);
    logic exp_ser;
    @(negedge clk);
    chk("fetch_serial", sel ? ser_b : ser_a, 1);
    chk("fetch_busy", sel ? busy_b : busy_a, 1);
    chk("fetch_pop", sel ? rd_b_o : rd_a_o, 0);
    for (int i = 0; i < w + 2; i++) begin
      for (int k = 0; k < c; k++) begin
        @(negedge clk);
        if (i == 0) exp_ser = 1'b0;
        else if (i == w + 1) exp_ser = 1'b1;
        else exp_ser = word[i-1];
        chk($sformatf("bit%0d_serial", i), sel ? ser_b : ser_a, exp_ser);
        chk("frame_done", sel ? fd_b : fd_a, (i == w + 1 && k == c - 1) ? 1 : 0);
        chk("busy", sel ? busy_b : busy_a, 1);
        chk("pop", sel ? rd_b_o : rd_a_o, (i == w + 1 && k == c - 1) ? pop_end : 1'b0);
        if (i == drop_en_at && k == 0) enable_a = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset with a word already queued: no pop while reset is high.
    push_a(8'hA5);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pop", rd_a_o, 0);
    chk("rst_serial", ser_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", fd_a, 0);
    reset_a = 1'b0;

    // Single frame 0xA5: 42 cycles from pop to end of stop.
    wait_pop(1'b0);
    frame(1'b0, 16'h00A5, 8, 4, 1'b0, -1);
    @(negedge clk);
    chk("a5_idle_busy", busy_a, 0);
    chk("a5_pops", pops_a, 1);

    // Back-to-back 0x00 then 0xFF: second pop in last stop cycle.
    push_a(8'h00);
    push_a(8'hFF);
    wait_pop(1'b0);
    frame(1'b0, 16'h0000, 8, 4, 1'b1, -1);
    frame(1'b0, 16'h00FF, 8, 4, 1'b0, -1);
    @(negedge clk);
    chk("b2b_pops", pops_a, 3);

    // Empty FIFO with enable high.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("empty_pop", rd_a_o, 0);
      chk("empty_busy", busy_a, 0);
      chk("empty_done", fd_a, 0);
      chk("empty_serial", ser_a, 1);
    end

    // Enable dropped during data bits: frame completes, no further pop.
    push_a(8'h3C);
    push_a(8'h99);
    wait_pop(1'b0);
    frame(1'b0, 16'h003C, 8, 4, 1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dis_pop", rd_a_o, 0);
      chk("dis_busy", busy_a, 0);
    end
    chk("dis_pops", pops_a, 4);
    enable_a = 1'b1;
    #1;
    chk("reen_pop", rd_a_o, 1);
    frame(1'b0, 16'h0099, 8, 4, 1'b0, -1);
    @(negedge clk);
    chk("reen_pops", pops_a, 5);

    // Reset during data bit 3 of 0x5A; next frame must carry 0x81.
    push_a(8'h5A);
    push_a(8'h81);
    wait_pop(1'b0);
    repeat (1 + 4 + 12 + 1) @(negedge clk);
    chk("bit3_serial", ser_a, 1);
    reset_a = 1'b1;
    #1;
    chk("rst_mid_pop", rd_a_o, 0);
    @(negedge clk);
    chk("rst_mid_serial", ser_a, 1);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_pop2", rd_a_o, 0);
    chk("rst_mid_done", fd_a, 0);
    reset_a = 1'b0;
    wait_pop(1'b0);
    frame(1'b0, 16'h0081, 8, 4, 1'b0, -1);
    @(negedge clk);
    chk("rst_pops", pops_a, 7);

    // CLKS_PER_BIT=1, WIDTH=16, word 0x8001.
    mem_b[0] = 16'h8001;
    wr_b = 1;
    reset_b = 1'b0;
    enable_b = 1'b1;
    wait_pop(1'b1);
    frame(1'b1, 16'h8001, 16, 1, 1'b0, -1);
    @(negedge clk);
    chk("b_idle_busy", busy_b, 0);
    chk("b_pops", pops_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
